// File: rtl/ready_retime_skid.sv
// ready_retime_skid
//   Two-entry register slice (main + skid) that breaks every combinational
//   path through a valid/ready handshake. in_ready, out_valid, out_data and
//   occupancy all come straight from flops. stall_cnt counts the cycles in
//   which the output holds valid data that downstream does not take.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream data valid
//   in_ready   block accepts input (registered)
//   in_data    upstream payload, WIDTH bits
//   out_valid  output payload valid (registered)
//   out_ready  downstream accepts
//   out_data   payload, driven from the main register
//   flush      synchronous discard of all held entries
//   occupancy  number of held entries, 0..2
//   stall_cnt  saturating count of output stall cycles, CNT_W bits
module ready_retime_skid #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic             in_ready_reg, in_ready_next;
  logic             out_valid_reg, out_valid_next;
  logic [1:0]       occupancy_reg, occupancy_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  logic in_fire;
  logic out_fire;

  // Handshakes use only registered ready/valid, so no path exists from
  // out_ready to in_ready or from in_valid/in_data to any output.
  assign in_fire  = in_valid & in_ready_reg;
  assign out_fire = out_valid_reg & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;

    case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          state_next = BUSY;
          main_next  = in_data;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_next = in_data;
        end else if (in_fire) begin
          state_next = FULL;
          skid_next  = in_data;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_next = BUSY;
          main_next  = skid_reg;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase

    // Flush empties the slice but leaves the data registers untouched;
    // any handshake in this cycle still completes, its data is just dropped.
    if (flush) begin
      state_next = EMPTY;
      main_next  = main_reg;
      skid_next  = skid_reg;
    end
  end

  // Handshake and occupancy outputs are precomputed from the next state so
  // they can be registered alongside it.
  always_comb begin
    in_ready_next  = (state_next != FULL);
    out_valid_next = (state_next != EMPTY);
    case (state_next)
      BUSY:    occupancy_next = 2'd1;
      FULL:    occupancy_next = 2'd2;
      default: occupancy_next = 2'd0;
    endcase
  end

  // A stall is a cycle with valid output that downstream refuses; this is
  // counted in flush cycles too. The counter sticks at all-ones.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (out_valid_reg && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_next = stall_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      main_reg      <= '0;
      skid_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      occupancy_reg <= 2'd0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
      skid_reg      <= skid_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      occupancy_reg <= occupancy_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = main_reg;
  assign occupancy = occupancy_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_ready_retime_skid.sv
// Testbench for ready_retime_skid. A queue-based model of the held entries
// (in acceptance order) and a saturating stall counter predict every output.
module tb_ready_retime_skid;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  ready_retime_skid #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q[$];
  int               m_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".occupancy"}, 32'(occupancy), 32'(q.size()));
    check({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    if (q.size() > 0) check({tag, ".out_data"}, 32'(out_data), 32'(q[0]));
  endtask

  // One clock cycle: drive inputs, predict from the model, clock, check.
  task automatic step(input string tag, input logic iv, input logic [WIDTH-1:0] id,
                      input logic ordy, input logic fl);
    logic m_in_fire, m_out_fire;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    m_in_fire  = iv && (q.size() < 2);
    m_out_fire = (q.size() > 0) && ordy;
    if ((q.size() > 0) && !ordy && (m_stall < SAT)) m_stall++;
    @(posedge clk);
    #1;
    if (m_out_fire) $display("%s: out data=%h", tag, q[0]);
    if (m_in_fire)  $display("%s: in  data=%h%s", tag, id, fl ? " (flushed)" : "");
    if (fl) begin
      q.delete();
    end else begin
      if (m_out_fire) void'(q.pop_front());
      if (m_in_fire)  q.push_back(id);
    end
    check_all(tag);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_stall = 0;
    check("reset.out_data", 32'(out_data), 32'h0);
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Streaming 0x01..0x08 with downstream always ready.
    for (int i = 1; i <= 8; i++) step("stream", 1'b1, WIDTH'(i), 1'b1, 1'b0);
    step("stream_tail", 1'b0, '0, 1'b1, 1'b0);
    step("stream_idle", 1'b0, '0, 1'b1, 1'b0);

    // Fill with downstream stalled, 0xC is held upstream.
    do_reset();
    step("fill_a", 1'b1, 16'h000A, 1'b0, 1'b0);
    step("fill_b", 1'b1, 16'h000B, 1'b0, 1'b0);
    step("fill_c", 1'b1, 16'h000C, 1'b0, 1'b0);
    step("fill_c", 1'b1, 16'h000C, 1'b0, 1'b0);
    // Drain from FULL while 0xC keeps being offered.
    step("drain", 1'b1, 16'h000C, 1'b1, 1'b0);
    step("drain", 1'b1, 16'h000C, 1'b1, 1'b0);
    step("drain", 1'b0, 16'h0000, 1'b1, 1'b0);
    step("drain", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush from FULL with downstream stalled.
    step("pre_flush", 1'b1, 16'h0011, 1'b0, 1'b0);
    step("pre_flush", 1'b1, 16'h0022, 1'b0, 1'b0);
    step("flush", 1'b1, 16'h0033, 1'b0, 1'b1);
    step("post_flush", 1'b0, 16'h0000, 1'b0, 1'b0);
    step("post_flush", 1'b1, 16'h0044, 1'b1, 1'b0);
    step("post_flush", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Saturation of the stall counter.
    do_reset();
    step("sat_load", 1'b1, 16'h00AA, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("sat", 1'b0, '0, 1'b0, 1'b0);
    step("sat_drain", 1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges while BUSY.
    do_reset();
    step("rst_busy", 1'b1, 16'h0BAD, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_stall = 0;
    check("midrst.out_data", 32'(out_data), 32'h0);
    check_all("midrst");
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("after_rst", 1'b0, '0, 1'b1, 1'b0);
    step("after_rst_in", 1'b1, 16'h0123, 1'b1, 1'b0);
    step("after_rst_out", 1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 4; i++) step("rand_drain", 1'b0, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net: never hang.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ready_retime_skid.md
READY_RETIME_SKID -- requirements
Module: ready_retime_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 128, data width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream data valid.
REQ-006 SHALL have port in_ready  output  1  block accepts input; driven directly from a flop.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  output payload valid; driven directly from state flops.
REQ-009 SHALL have port out_ready  input  1  downstream accepts.
REQ-010 SHALL have port out_data  output  WIDTH  payload; driven directly from the main register.
REQ-011 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-012 SHALL have port occupancy  output  2  number of held entries, 0..2.
REQ-013 SHALL have port stall_cnt  output  CNT_W  saturating count of output stall cycles.

Function
REQ-014 SHALL hold two entries, main and skid, so no combinational path exists from out_ready to in_ready or from in_valid/in_data to any output.
REQ-015 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready, both evaluated in the current cycle.
REQ-016 SHALL implement states EMPTY (occupancy 0), BUSY (occupancy 1, main valid), FULL (occupancy 2, main and skid valid).
REQ-017 SHALL drive out_valid = 1 in BUSY and FULL only, and in_ready = 1 in EMPTY and BUSY only.
REQ-018 EMPTY: in_fire -> BUSY, main <= in_data; otherwise stay.
REQ-019 BUSY: in_fire & out_fire -> BUSY, main <= in_data; in_fire & !out_fire -> FULL, skid <= in_data; !in_fire & out_fire -> EMPTY; neither -> stay.
REQ-020 FULL: out_fire -> BUSY, main <= skid; otherwise stay; no input is accepted because in_ready = 0.
REQ-021 SHALL present data in acceptance order; no entry is dropped, duplicated or reordered.
REQ-022 SHALL have a minimum latency of one cycle: data accepted at edge N is on out_data with out_valid = 1 after edge N.
REQ-023 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-024 SHALL hold out_data stable while out_valid = 1 and out_ready = 0.
REQ-025 flush = 1 SHALL force next state EMPTY regardless of other inputs and take priority over every transition.
REQ-026 In a flush cycle, an out_fire is a completed transfer; an in_fire is a completed handshake whose data is discarded.
REQ-027 flush SHALL NOT modify main/skid data contents or stall_cnt.
REQ-028 stall_cnt SHALL increment by 1 each cycle with out_valid = 1 and out_ready = 0, including flush cycles.
REQ-029 stall_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-030 occupancy SHALL equal 0/1/2 for EMPTY/BUSY/FULL, registered with the state.

Reset
REQ-031 On rst_n = 0, state SHALL become EMPTY immediately, asynchronously to clk.
REQ-032 Reset values: in_ready = 1, out_valid = 0, out_data = 0, skid = 0, occupancy = 0, stall_cnt = 0.
REQ-033 Reset asserted mid-transfer SHALL discard all held entries, and no handshake SHALL complete in that cycle.
REQ-034 After rst_n deasserts, the first rising edge SHALL be a normal functional edge.

Verification
REQ-035 Streaming: out_ready = 1, send 0x01..0x08 back-to-back -> outputs 0x01..0x08 in order, one per cycle, one-cycle latency, stall_cnt = 0.
REQ-036 Fill: out_ready = 0, offer 0xA, 0xB, 0xC -> 0xA, 0xB accepted, occupancy = 2, in_ready = 0 on the next cycle, 0xC held upstream, stall_cnt increments each cycle.
REQ-037 Drain from FULL: then out_ready = 1 -> 0xA, 0xB, 0xC delivered in order, with no gap and no duplicate.
REQ-038 Flush: in FULL, pulse flush with out_ready = 0 -> next cycle occupancy = 0, out_valid = 0, in_ready = 1, stall_cnt unchanged except the flush-cycle increment.
REQ-039 Saturation: CNT_W = 4, hold a stall for 20 cycles -> stall_cnt stops at 15.
REQ-040 Reset mid-operation: assert rst_n = 0 between edges in BUSY -> outputs take their reset values immediately, and the held entry never appears.
